// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU definitions for the register file / scoreboard slice.
//   REG_COUNT      : number of architectural registers
//   REG_ADDR_WIDTH : width of a register index
//   reg_idx_t      : register index type
//   reg_mask_t     : one bit per register (busy vector, decoded enables)
package regfile_scoreboard_pkg;

  localparam int unsigned REG_COUNT      = 8;
  localparam int unsigned REG_ADDR_WIDTH = 3;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [REG_COUNT-1:0]      reg_mask_t;

endpackage

// File: rtl/regfile_scoreboard_decoder8en.sv
// decoder8en: 3-to-8 one-hot decoder with enable.
//   i_en   : enable; output is all-zero when low
//   i_addr : index to decode
//   o_dec  : one-hot select, bit i_addr set when enabled
module decoder8en
  import regfile_scoreboard_pkg::*;
(
  input  logic      i_en,
  input  reg_idx_t  i_addr,
  output reg_mask_t o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_en) o_dec[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 8-entry register file with write-through bypass and
// a busy-bit scoreboard that stalls on RAW and WAW hazards.
//   clk, reset        : clock, asynchronous active-high reset
//   wen/waddr/wdata   : write-back port (also clears busy[waddr])
//   asel/bsel         : read indices; adata/bdata combinational read data
//   ause/buse         : operand A/B needed this cycle (RAW hazard check)
//   iss_en/iss_addr   : issue request reserving destination iss_addr
//   stall             : combinational hazard indication
//   busy              : registered pending-write bit per register
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen,
  input  reg_idx_t         waddr,
  input  logic [WIDTH-1:0] wdata,
  input  reg_idx_t         asel,
  input  reg_idx_t         bsel,
  input  logic             ause,
  input  logic             buse,
  output logic [WIDTH-1:0] adata,
  output logic [WIDTH-1:0] bdata,
  input  logic             iss_en,
  input  reg_idx_t         iss_addr,
  output logic             stall,
  output reg_mask_t        busy
);

  logic [WIDTH-1:0] r_regs [REG_COUNT];
  reg_mask_t        r_busy;

  reg_mask_t        w_wr_dec;
  reg_mask_t        w_set_dec;
  logic             w_a_byp;
  logic             w_b_byp;
  logic             w_iss_byp;
  logic             w_a_haz;
  logic             w_b_haz;
  logic             w_waw_haz;
  logic             w_iss_ok;

  // A same-cycle write-back to the register in question both forwards
  // its data and resolves the hazard on it.
  assign w_a_byp   = wen && (waddr == asel);
  assign w_b_byp   = wen && (waddr == bsel);
  assign w_iss_byp = wen && (waddr == iss_addr);

  assign adata = w_a_byp ? wdata : r_regs[asel];
  assign bdata = w_b_byp ? wdata : r_regs[bsel];

  assign w_a_haz   = ause   && r_busy[asel]     && !w_a_byp;
  assign w_b_haz   = buse   && r_busy[bsel]     && !w_b_byp;
  assign w_waw_haz = iss_en && r_busy[iss_addr] && !w_iss_byp;

  assign stall    = w_a_haz || w_b_haz || w_waw_haz;
  assign w_iss_ok = iss_en && !stall;
  assign busy     = r_busy;

  decoder8en u_wr_dec (
    .i_en   (wen),
    .i_addr (waddr),
    .o_dec  (w_wr_dec)
  );

  decoder8en u_set_dec (
    .i_en   (w_iss_ok),
    .i_addr (iss_addr),
    .o_dec  (w_set_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (w_wr_dec[i]) r_regs[i] <= wdata;
      end
    end
  end

  // Clear on write-back first, then set on accepted issue, so a
  // same-index issue and write-back leave the register reserved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_wr_dec) | w_set_dec;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  asel, bsel;
  logic        ause, buse;
  logic [15:0] adata, bdata;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic        stall;
  logic [7:0]  busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: register contents and set of reserved registers.
  logic [15:0] m_reg [8];
  bit          m_res [8];

  always #10 clk = ~clk;

  regfile_scoreboard #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .asel(asel), .bsel(bsel), .ause(ause), .buse(buse),
    .adata(adata), .bdata(bdata), .iss_en(iss_en), .iss_addr(iss_addr),
    .stall(stall), .busy(busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] sel);
    if (wen && waddr == sel) return wdata;
    return m_reg[sel];
  endfunction

  function automatic bit m_stall();
    bit ha, hb, hw;
    ha = ause   && m_res[asel]     && !(wen && waddr == asel);
    hb = buse   && m_res[bsel]     && !(wen && waddr == bsel);
    hw = iss_en && m_res[iss_addr] && !(wen && waddr == iss_addr);
    return ha || hb || hw;
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_res[i];
    return v;
  endfunction

  // Present inputs just after a falling edge and check combinational outputs.
  task automatic apply(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] as, input logic [2:0] bs,
                       input logic au, input logic bu,
                       input logic ie, input logic [2:0] ia);
    wen = we; waddr = wa; wdata = wd; asel = as; bsel = bs;
    ause = au; buse = bu; iss_en = ie; iss_addr = ia;
    #1;
    check("adata", adata, m_read(asel));
    check("bdata", bdata, m_read(bsel));
    check("stall", {15'd0, stall}, {15'd0, m_stall()});
  endtask

  // Clock edge: advance the reference, then check busy after the edge.
  task automatic tick();
    bit acc;
    acc = iss_en && !m_stall();
    @(posedge clk);
    if (wen) begin
      m_reg[waddr] = wdata;
      m_res[waddr] = 1'b0;
    end
    if (acc) m_res[iss_addr] = 1'b1;
    #1;
    check("busy", {8'd0, busy}, {8'd0, m_busy()});
    @(negedge clk);
  endtask

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = '0;
      m_res[i] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    wen = 0; waddr = 0; wdata = 0; asel = 0; bsel = 0;
    ause = 0; buse = 0; iss_en = 0; iss_addr = 0;
    m_clear();
    repeat (2) @(negedge clk);
    check("rst_busy", {8'd0, busy}, 16'h0000);
    check("rst_stall", {15'd0, stall}, 16'h0000);
    check("rst_adata", adata, 16'h0000);
    reset = 1'b0;
    #1;

    // Write then read, with bypass during the write cycle.
    apply(1, 3, 16'hBEEF, 3, 0, 0, 0, 0, 0);
    check("byp_adata", adata, 16'hBEEF);
    tick();
    apply(0, 0, 16'h0, 3, 3, 0, 0, 0, 0);
    check("rd_adata", adata, 16'hBEEF);
    check("rd_bdata", bdata, 16'hBEEF);
    tick();

    // RAW hazard resolved by same-cycle write-back.
    apply(0, 0, 16'h0, 0, 0, 0, 0, 1, 5);
    tick();
    check("iss5_busy", {8'd0, busy}, 16'h0020);
    apply(0, 0, 16'h0, 5, 0, 1, 0, 0, 0);
    check("raw_stall", {15'd0, stall}, 16'h0001);
    tick();
    apply(1, 5, 16'h0042, 5, 0, 1, 0, 0, 0);
    check("raw_byp_stall", {15'd0, stall}, 16'h0000);
    check("raw_byp_adata", adata, 16'h0042);
    tick();
    check("wb5_busy", {8'd0, busy}, 16'h0000);

    // WAW hazard; issue plus write-back to the same index keeps it busy.
    apply(0, 0, 16'h0, 0, 0, 0, 0, 1, 2);
    tick();
    apply(0, 0, 16'h0, 0, 0, 0, 0, 1, 2);
    check("waw_stall", {15'd0, stall}, 16'h0001);
    tick();
    check("waw_busy", {8'd0, busy}, 16'h0004);
    apply(1, 2, 16'h2222, 0, 0, 0, 0, 1, 2);
    check("setwins_stall", {15'd0, stall}, 16'h0000);
    tick();
    check("setwins_busy", {8'd0, busy}, 16'h0004);
    apply(1, 2, 16'h2223, 0, 0, 0, 0, 0, 0);
    tick();

    // Port B hazard only while buse is asserted.
    apply(0, 0, 16'h0, 0, 0, 0, 0, 1, 7);
    tick();
    apply(0, 0, 16'h0, 0, 7, 0, 1, 0, 0);
    check("b_stall", {15'd0, stall}, 16'h0001);
    tick();
    apply(0, 0, 16'h0, 0, 7, 0, 0, 0, 0);
    check("b_nostall", {15'd0, stall}, 16'h0000);
    tick();
    apply(1, 7, 16'h7777, 0, 0, 0, 0, 0, 0);
    tick();

    // Write-back to a non-busy register updates data only.
    apply(1, 1, 16'h1234, 0, 0, 0, 0, 0, 0);
    tick();
    check("nb_busy", {8'd0, busy}, 16'h0000);
    apply(0, 0, 16'h0, 1, 1, 0, 0, 0, 0);
    check("nb_adata", adata, 16'h1234);

    // Fill all registers, reserve one, then reset asynchronously mid-cycle.
    for (int i = 0; i < 8; i++) begin
      apply(1, 3'(i), 16'(16'h1111 * i), 0, 0, 0, 0, 0, 0);
      tick();
    end
    apply(0, 0, 16'h0, 6, 6, 0, 0, 1, 4);
    tick();
    apply(0, 0, 16'h0, 6, 6, 0, 0, 0, 0);
    check("fill_r6", adata, 16'h6666);
    #2;
    reset = 1'b1;
    m_clear();
    #1;
    check("arst_busy", {8'd0, busy}, 16'h0000);
    check("arst_stall", {15'd0, stall}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      asel = 3'(i); bsel = 3'(7 - i);
      #1;
      check("arst_adata", adata, 16'h0000);
      check("arst_bdata", bdata, 16'h0000);
    end
    // Write and issue held during reset must be ignored.
    @(negedge clk);
    wen = 1; waddr = 0; wdata = 16'hDEAD; iss_en = 1; iss_addr = 0;
    @(negedge clk);
    wen = 0; iss_en = 0; asel = 0;
    reset = 1'b0;
    #1;
    check("post_rst_busy", {8'd0, busy}, 16'h0000);
    check("post_rst_r0", adata, 16'h0000);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      r = $urandom;
      apply(r[0] & r[1], 3'($urandom_range(7)), 16'($urandom),
            3'($urandom_range(7)), 3'($urandom_range(7)),
            r[2], r[3], r[4] | r[5], 3'($urandom_range(7)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
